// File: rtl/alu.sv
// Hack-style ALU (zx/nx/zy/ny/f/no) with a single registered output stage.
// Optional zr/ng flag outputs are compiled in when ALU_FLAGS_EN is defined.
module alu #(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    input  logic             zx,
    input  logic             nx,
    input  logic             zy,
    input  logic             ny,
    input  logic             f,
    input  logic             no,
    output logic [WIDTH-1:0] out,
`ifdef ALU_FLAGS_EN
    output logic             zr,
    output logic             ng,
`endif
    output logic             out_valid
);

    logic [WIDTH-1:0] x_z_c;
    logic [WIDTH-1:0] x_p_c;
    logic [WIDTH-1:0] y_z_c;
    logic [WIDTH-1:0] y_p_c;
    logic [WIDTH-1:0] r_c;
    logic [WIDTH-1:0] res_c;

    logic [WIDTH-1:0] out_q;
    logic [WIDTH-1:0] out_d;
    logic             valid_q;
    logic             valid_d;

    // Operand preconditioning, function select and output negate
    always_comb begin
        x_z_c = zx ? '0 : x;
        x_p_c = nx ? ~x_z_c : x_z_c;
        y_z_c = zy ? '0 : y;
        y_p_c = ny ? ~y_z_c : y_z_c;
        r_c   = f ? WIDTH'(x_p_c + y_p_c) : (x_p_c & y_p_c);
        res_c = no ? ~r_c : r_c;
    end

    // Result is captured only on accepted cycles; otherwise it holds
    always_comb begin
        out_d   = out_q;
        valid_d = in_valid;
        if (in_valid) begin
            out_d = res_c;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_q   <= '0;
            valid_q <= 1'b0;
        end else begin
            out_q   <= out_d;
            valid_q <= valid_d;
        end
    end

    assign out       = out_q;
    assign out_valid = valid_q;

`ifdef ALU_FLAGS_EN
    logic zr_q;
    logic zr_d;
    logic ng_q;
    logic ng_d;

    // Flags track the registered result and share its capture condition
    always_comb begin
        zr_d = zr_q;
        ng_d = ng_q;
        if (in_valid) begin
            zr_d = (res_c == '0);
            ng_d = res_c[WIDTH-1];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            zr_q <= 1'b0;
            ng_q <= 1'b0;
        end else begin
            zr_q <= zr_d;
            ng_q <= ng_d;
        end
    end

    assign zr = zr_q;
    assign ng = ng_q;
`endif

endmodule

// File: tb/tb_alu.sv
// Self-checking bench for alu: directed literal cases plus randomized traffic
// compared every cycle against an arithmetic reference model.
module tb_alu;

    localparam int unsigned W = 16;

    logic         clk;
    logic         rst_n;
    logic         in_valid;
    logic [W-1:0] x;
    logic [W-1:0] y;
    logic [5:0]   ctrl;
    logic [W-1:0] out;
    logic         out_valid;
`ifdef ALU_FLAGS_EN
    logic         zr;
    logic         ng;
`endif

    int checks   = 0;
    int failures = 0;

    logic [W-1:0] exp_out   = '0;
    logic         exp_valid = 1'b0;
    logic         exp_zr    = 1'b0;
    logic         exp_ng    = 1'b0;

    alu #(.WIDTH(W)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .x        (x),
        .y        (y),
        .zx       (ctrl[5]),
        .nx       (ctrl[4]),
        .zy       (ctrl[3]),
        .ny       (ctrl[2]),
        .f        (ctrl[1]),
        .no       (ctrl[0]),
        .out      (out),
`ifdef ALU_FLAGS_EN
        .zr       (zr),
        .ng       (ng),
`endif
        .out_valid(out_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: plain integer arithmetic; negation as (2^W-1) - v
    function automatic logic [W-1:0] ref_alu(input logic [W-1:0] xv, input logic [W-1:0] yv,
                                             input logic [5:0] c);
        longint m;
        longint a;
        longint b;
        longint r;
        m = (longint'(1) << W) - 1;
        a = c[5] ? 0 : longint'(xv);
        if (c[4]) a = m - a;
        b = c[3] ? 0 : longint'(yv);
        if (c[2]) b = m - b;
        r = c[1] ? (a + b) % (m + 1) : (a & b);
        if (c[0]) r = m - r;
        return W'(r);
    endfunction

    // Model state: one-cycle latency, hold when idle, cleared by reset
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            exp_out   = '0;
            exp_valid = 1'b0;
            exp_zr    = 1'b0;
            exp_ng    = 1'b0;
        end else begin
            exp_valid = in_valid;
            if (in_valid) begin
                exp_out = ref_alu(x, y, ctrl);
                exp_zr  = (exp_out == 0);
                exp_ng  = exp_out[W-1];
            end
        end
    end

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, req, $time);
        end
    endtask

    // Per-cycle compare against the model
    always @(negedge clk) begin
        chk("cyc_out", out, exp_out);
        chk("cyc_valid", W'(out_valid), W'(exp_valid));
`ifdef ALU_FLAGS_EN
        chk("cyc_zr", W'(zr), W'(exp_zr));
        chk("cyc_ng", W'(ng), W'(exp_ng));
`endif
    end

    // Apply inputs at a falling edge and wait until the next falling edge
    task automatic drive(input logic v, input logic [W-1:0] xv, input logic [W-1:0] yv,
                         input logic [5:0] c);
        in_valid = v;
        x        = xv;
        y        = yv;
        ctrl     = c;
        @(negedge clk);
    endtask

    task automatic lit(input string name, input logic [W-1:0] o, input logic v,
                       input logic z, input logic n);
        chk({name, "_out"}, out, o);
        chk({name, "_valid"}, W'(out_valid), W'(v));
`ifdef ALU_FLAGS_EN
        chk({name, "_zr"}, W'(zr), W'(z));
        chk({name, "_ng"}, W'(ng), W'(n));
`else
        if (z === 1'bx || n === 1'bx) $display("note: undefined flag literal in %s", name);
`endif
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [W-1:0] rx;
        logic [W-1:0] ry;
        rst_n    = 1'b0;
        in_valid = 1'b0;
        x        = '0;
        y        = '0;
        ctrl     = '0;
        repeat (3) @(negedge clk);
        lit("reset_init", 16'h0000, 1'b0, 1'b0, 1'b0);
        rst_n = 1'b1;
        @(negedge clk);

        drive(1'b1, 16'h0008, 16'h0018, 6'b111100);
        lit("minus1", 16'hFFFF, 1'b1, 1'b0, 1'b1);
        drive(1'b1, 16'h0008, 16'h0018, 6'b000010);
        lit("add", 16'h0020, 1'b1, 1'b0, 1'b0);
        drive(1'b1, 16'h0008, 16'h0018, 6'b010011);
        lit("x_minus_y", 16'hFFF0, 1'b1, 1'b0, 1'b1);
        drive(1'b1, 16'h0008, 16'h0018, 6'b111111);
        lit("one", 16'h0001, 1'b1, 1'b0, 1'b0);
        drive(1'b1, 16'h0008, 16'h0018, 6'b101010);
        lit("zero", 16'h0000, 1'b1, 1'b1, 1'b0);
        drive(1'b1, 16'hFFFF, 16'h0001, 6'b000010);
        lit("wrap", 16'h0000, 1'b1, 1'b1, 1'b0);
        drive(1'b1, 16'h0008, 16'h0018, 6'b000000);
        lit("and", 16'h0008, 1'b1, 1'b0, 1'b0);

        drive(1'b0, 16'h1234, 16'h4321, 6'b111100);
        lit("idle_hold1", 16'h0008, 1'b0, 1'b0, 1'b0);
        drive(1'b0, 16'hFFFF, 16'hFFFF, 6'b010011);
        lit("idle_hold2", 16'h0008, 1'b0, 1'b0, 1'b0);

        drive(1'b1, 16'h0008, 16'h0018, 6'b000010);
        lit("b2b_0", 16'h0020, 1'b1, 1'b0, 1'b0);
        drive(1'b1, 16'h0008, 16'h0018, 6'b010011);
        lit("b2b_1", 16'hFFF0, 1'b1, 1'b0, 1'b1);
        drive(1'b1, 16'h0008, 16'h0018, 6'b111111);
        lit("b2b_2", 16'h0001, 1'b1, 1'b0, 1'b0);

        // Reset mid-cycle with a result pending
        in_valid = 1'b1;
        ctrl     = 6'b111100;
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1 lit("reset_mid", 16'h0000, 1'b0, 1'b0, 1'b0);
        in_valid = 1'b0;
        @(negedge clk);
        lit("reset_held", 16'h0000, 1'b0, 1'b0, 1'b0);
        rst_n = 1'b1;
        @(negedge clk);
        lit("post_reset", 16'h0000, 1'b0, 1'b0, 1'b0);

        for (int i = 0; i < 400; i++) begin
            rx = W'($urandom);
            ry = W'($urandom);
            case ($urandom_range(0, 7))
                0: rx = '0;
                1: rx = '1;
                2: ry = W'(16'h8000);
                3: ry = W'(0) - rx;
                default: ;
            endcase
            drive(($urandom_range(0, 9) < 7), rx, ry, 6'($urandom));
        end
        in_valid = 1'b0;
        repeat (2) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
